// File: rtl/rb1_arbiter.sv
// Round-robin two-master arbiter owning the RB1 32x8 register bank pins.
// Define RB1_ARB_BURST_LIMIT_EN to preempt a grant after MAX_BURST commands.
module rb1_arbiter #(
  parameter int MAX_BURST = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req,
  input  logic       m1_req,
  output logic       m0_gnt,
  output logic       m1_gnt,
  input  logic       m0_cmd_valid,
  input  logic       m1_cmd_valid,
  input  logic       m0_rw,
  input  logic       m1_rw,
  input  logic [4:0] m0_addr,
  input  logic [4:0] m1_addr,
  input  logic [7:0] m0_wdata,
  input  logic [7:0] m1_wdata,
  output logic       m0_rvalid,
  output logic       m1_rvalid,
  output logic [7:0] m0_rdata,
  output logic [7:0] m1_rdata,
  output logic       RB1_RW,
  output logic [4:0] RB1_A,
  output logic [7:0] RB1_D,
  input  logic [7:0] RB1_Q
);

  typedef enum logic [1:0] {
    IDLE,
    G0,
    G1,
    TURN
  } state_t;

  state_t state;
  logic   last;
  logic   owner;
  logic   acc0;
  logic   acc1;
  logic   acc;
  logic   cmd_rw;
  logic   [4:0] cmd_addr;
  logic   [7:0] cmd_wdata;
  logic   rd_pend;
  logic   rd_tag;
  logic   lim0;
  logic   lim1;

  assign acc0 = m0_gnt && m0_req && m0_cmd_valid;
  assign acc1 = m1_gnt && m1_req && m1_cmd_valid;
  assign acc  = acc0 || acc1;

  assign cmd_rw    = acc1 ? m1_rw    : m0_rw;
  assign cmd_addr  = acc1 ? m1_addr  : m0_addr;
  assign cmd_wdata = acc1 ? m1_wdata : m0_wdata;

`ifdef RB1_ARB_BURST_LIMIT_EN
  localparam logic [4:0] LAST_CMD = 5'(MAX_BURST - 1);

  logic [4:0] cnt;

  // Saturates so a lone master can stream indefinitely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == TURN) begin
      cnt <= '0;
    end else if (acc && cnt != 5'd31) begin
      cnt <= cnt + 5'd1;
    end
  end

  assign lim0 = acc0 && m1_req && (cnt >= LAST_CMD);
  assign lim1 = acc1 && m0_req && (cnt >= LAST_CMD);
`else
  logic [4:0] unused_max_burst;
  assign unused_max_burst = 5'(MAX_BURST);
  assign lim0 = 1'b0;
  assign lim1 = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      m0_gnt <= 1'b0;
      m1_gnt <= 1'b0;
    end else begin
      m0_gnt <= 1'b0;
      m1_gnt <= 1'b0;
      unique case (state)
        IDLE: begin
          if (m0_req && (!m1_req || last)) begin
            state  <= G0;
            owner  <= 1'b0;
            m0_gnt <= 1'b1;
          end else if (m1_req) begin
            state  <= G1;
            owner  <= 1'b1;
            m1_gnt <= 1'b1;
          end
        end
        G0: begin
          if (!m0_req || lim0) begin
            state <= TURN;
          end else begin
            m0_gnt <= 1'b1;
          end
        end
        G1: begin
          if (!m1_req || lim1) begin
            state <= TURN;
          end else begin
            m1_gnt <= 1'b1;
          end
        end
        TURN: begin
          // Prefer the other master, else give it back to the previous owner.
          if (owner ? m0_req : m1_req) begin
            state  <= owner ? G0 : G1;
            owner  <= !owner;
            m0_gnt <= owner;
            m1_gnt <= !owner;
          end else if (owner ? m1_req : m0_req) begin
            state  <= owner ? G1 : G0;
            m0_gnt <= !owner;
            m1_gnt <= owner;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RB1_RW    <= 1'b1;
      RB1_A     <= '0;
      RB1_D     <= '0;
      rd_pend   <= 1'b0;
      rd_tag    <= 1'b0;
      last      <= 1'b1;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      RB1_RW  <= 1'b1;
      rd_pend <= 1'b0;
      if (acc) begin
        RB1_RW  <= cmd_rw;
        RB1_A   <= cmd_addr;
        RB1_D   <= cmd_wdata;
        rd_pend <= cmd_rw;
        rd_tag  <= acc1;
        last    <= acc1;
      end
      // Tag travels with the command so late reads reach the right master.
      m0_rvalid <= rd_pend && !rd_tag;
      m1_rvalid <= rd_pend && rd_tag;
      if (rd_pend && !rd_tag) begin
        m0_rdata <= RB1_Q;
      end
      if (rd_pend && rd_tag) begin
        m1_rdata <= RB1_Q;
      end
    end
  end

endmodule

// File: tb/tb_rb1_arbiter.sv
// Directed bench for rb1_arbiter with a behavioural RB1 bank model.
// Expected burst behaviour follows RB1_ARB_BURST_LIMIT_EN.
module tb_rb1_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       m0_req = 1'b0;
  logic       m1_req = 1'b0;
  logic       m0_gnt;
  logic       m1_gnt;
  logic       m0_cmd_valid = 1'b0;
  logic       m1_cmd_valid = 1'b0;
  logic       m0_rw = 1'b1;
  logic       m1_rw = 1'b1;
  logic [4:0] m0_addr = '0;
  logic [4:0] m1_addr = '0;
  logic [7:0] m0_wdata = '0;
  logic [7:0] m1_wdata = '0;
  logic       m0_rvalid;
  logic       m1_rvalid;
  logic [7:0] m0_rdata;
  logic [7:0] m1_rdata;
  logic       rb1_rw;
  logic [4:0] rb1_a;
  logic [7:0] rb1_d;
  logic [7:0] rb1_q;

  logic [7:0] bank [32];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rb1_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .m0_req       (m0_req),
    .m1_req       (m1_req),
    .m0_gnt       (m0_gnt),
    .m1_gnt       (m1_gnt),
    .m0_cmd_valid (m0_cmd_valid),
    .m1_cmd_valid (m1_cmd_valid),
    .m0_rw        (m0_rw),
    .m1_rw        (m1_rw),
    .m0_addr      (m0_addr),
    .m1_addr      (m1_addr),
    .m0_wdata     (m0_wdata),
    .m1_wdata     (m1_wdata),
    .m0_rvalid    (m0_rvalid),
    .m1_rvalid    (m1_rvalid),
    .m0_rdata     (m0_rdata),
    .m1_rdata     (m1_rdata),
    .RB1_RW       (rb1_rw),
    .RB1_A        (rb1_a),
    .RB1_D        (rb1_d),
    .RB1_Q        (rb1_q)
  );

  // Bank: sync write while RW low, combinational read.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        bank[i] <= (i == 5) ? 8'hA5 : 8'(8'h40 + i);
      end
    end else if (!rb1_rw) begin
      bank[rb1_a] <= rb1_d;
    end
  end

  assign rb1_q = bank[rb1_a];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int         rv_cnt;
  logic [7:0] rv_last;

  initial begin
    #1 rst = 1'b1;
    tick();
    tick();
    chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
    chk("rst_rw", rb1_rw, 1);
    chk("rst_a", rb1_a, 0);
    chk("rst_d", rb1_d, 0);
    chk("rst_rv", {m0_rvalid, m1_rvalid}, 0);
    rst = 1'b0;
    tick();

    // First tie after reset goes to m0; m0 reads addr 5.
    m0_req = 1; m1_req = 1;
    tick();
    chk("tie1_g0", m0_gnt, 1);
    chk("tie1_g1", m1_gnt, 0);
    m0_cmd_valid = 1; m0_rw = 1; m0_addr = 5;
    tick();
    chk("rd_a", rb1_a, 5);
    chk("rd_rw", rb1_rw, 1);
    m0_cmd_valid = 0; m0_req = 0;
    tick();
    chk("turn_gnt", {m0_gnt, m1_gnt}, 0);
    chk("rd_rv0", m0_rvalid, 1);
    chk("rd_q0", m0_rdata, 8'hA5);
    chk("rd_rv1", m1_rvalid, 0);
    tick();
    chk("hand_g1", m1_gnt, 1);

    // m1 write then read-back of addr 17.
    m1_cmd_valid = 1; m1_rw = 0; m1_addr = 17; m1_wdata = 8'h3C;
    tick();
    chk("wr_rw", rb1_rw, 0);
    chk("wr_a", rb1_a, 17);
    chk("wr_d", rb1_d, 8'h3C);
    m1_rw = 1;
    tick();
    chk("wr_rw1", rb1_rw, 1);
    chk("rb_a", rb1_a, 17);
    m1_cmd_valid = 0;
    tick();
    chk("rb_rv1", m1_rvalid, 1);
    chk("rb_q1", m1_rdata, 8'h3C);
    chk("rb_rv0", m0_rvalid, 0);
    m1_req = 0;
    tick();
    tick();
    chk("idle_gnt", {m0_gnt, m1_gnt}, 0);

    // Second tie: m1 served last, so m0 wins.
    m0_req = 1; m1_req = 1;
    tick();
    chk("tie2_g0", m0_gnt, 1);
    chk("tie2_g1", m1_gnt, 0);

    // m1 command while m0 owns the bank must be dropped.
    m0_cmd_valid = 1; m0_rw = 1; m0_addr = 3;
    m1_cmd_valid = 1; m1_rw = 0; m1_addr = 9; m1_wdata = 8'hFF;
    tick();
    chk("ign_a", rb1_a, 3);
    chk("ign_rw", rb1_rw, 1);
    m0_cmd_valid = 0;
    tick();
    chk("ign_rw2", rb1_rw, 1);
    chk("ign_a2", rb1_a, 3);
    chk("ign_rv0", m0_rvalid, 1);
    chk("ign_q0", m0_rdata, 8'h43);
    chk("ign_rv1", m1_rvalid, 0);
    m1_cmd_valid = 0; m0_req = 0;
    tick();
    tick();
    chk("ign_g1", m1_gnt, 1);
    m1_req = 0;
    tick();
    tick();
    chk("idle2_gnt", {m0_gnt, m1_gnt}, 0);

    // m0 streams 20 reads while m1 waits.
    m0_req = 1;
    tick();
    chk("bst_g0", m0_gnt, 1);
    m1_req = 1;
    rv_cnt = 0;
    rv_last = '0;
    for (int k = 0; k < 24; k++) begin
      m0_cmd_valid = (k < 20);
      m0_rw = 1;
      m0_addr = 5'(k + 8);
      if (k == 20) m0_req = 0;
      tick();
      if (m0_rvalid) begin
        rv_cnt++;
        rv_last = m0_rdata;
      end
      if (k + 1 == 18) chk("bst_g1_18", m1_gnt, 0);
`ifdef RB1_ARB_BURST_LIMIT_EN
      if (k + 1 == 19) chk("bst_g1_19", m1_gnt, 1);
`else
      if (k + 1 == 19) chk("bst_g1_19", m1_gnt, 0);
`endif
      if (k + 1 == 22) chk("bst_g1_22", m1_gnt, 1);
    end
`ifdef RB1_ARB_BURST_LIMIT_EN
    chk("bst_cnt", rv_cnt, 18);
    chk("bst_last", rv_last, 8'h59);
`else
    chk("bst_cnt", rv_cnt, 20);
    chk("bst_last", rv_last, 8'h5B);
`endif

    // Reset during G1 with a read in flight.
    m1_cmd_valid = 1; m1_rw = 1; m1_addr = 5;
    tick();
    chk("mid_a", rb1_a, 5);
    rst = 1;
    #1;
    chk("mr_gnt", {m0_gnt, m1_gnt}, 0);
    chk("mr_rv", {m0_rvalid, m1_rvalid}, 0);
    chk("mr_rw", rb1_rw, 1);
    chk("mr_a", rb1_a, 0);
    chk("mr_d", rb1_d, 0);
    chk("mr_q0", m0_rdata, 0);
    chk("mr_q1", m1_rdata, 0);
    m1_cmd_valid = 0; m0_req = 0; m1_req = 0;
    tick();
    chk("mr_rv1", m1_rvalid, 0);
    rst = 0;
    m0_req = 1; m1_req = 1;
    tick();
    chk("tie3_g0", m0_gnt, 1);
    chk("tie3_g1", m1_gnt, 0);
    chk("tie3_rv", {m0_rvalid, m1_rvalid}, 0);
    tick();
    chk("tie3_rv2", {m0_rvalid, m1_rvalid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rb1_arbiter.md
# rb1_arbiter

Two-master arbiter for the single-port 32x8 register bank RB1. It shares the bank between the frame loader (master 0) and the serial transmitter (master 1), which reads 18 rows per 8-frame burst. Grants are exclusive with round-robin fairness, and a dead turnaround cycle separates grants. The arbiter owns the RB1 control pins outright, and all bank traffic passes through it.

## Interface
- MAX_BURST, 18 — commands one master may issue per grant when the other is waiting (only with burst limit compiled in)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- m0_req / m1_req  in  1  request; held high for the whole burst
- m0_gnt / m1_gnt  out  1  registered grant
- m0_cmd_valid / m1_cmd_valid  in  1  command strobe; accepted only when that master's gnt is high
- m0_rw / m1_rw  in  1  1 = read, 0 = write
- m0_addr / m1_addr  in  5  bank address
- m0_wdata / m1_wdata  in  8  write data
- m0_rvalid / m1_rvalid  out  1  one-cycle read-data pulse
- m0_rdata / m1_rdata  out  8  read data; holds until the next read returns to that master
- RB1_RW  out  1  bank read/write, 0 = write
- RB1_A  out  5  bank address
- RB1_D  out  8  bank write data
- RB1_Q  in  8  bank read data; combinational from RB1_A

## Operation
- FSM states: IDLE, G0, G1, TURN. mN_gnt = (state == GN), registered.
- IDLE: if any req is high, go to G0 or G1.
  - Only one req high: that master wins.
  - Both high: the master not served last wins. The last-served pointer resets to 1, so m0 wins the first tie.
- GN: each accepted command updates a 5-bit burst counter and the last-served pointer. Leave for TURN on the edge where mN_req is sampled low. Commands arriving with req low are ignored.
- TURN: lasts exactly 1 cycle with both gnts low.
  - Next state is G of the other master if its req is high.
  - Otherwise G of the same master if its req is high.
  - Otherwise IDLE.
  - The burst counter clears in TURN.
- Accepted command: registered onto the bank pins on the next edge, with RB1_A = addr and RB1_D = wdata.
  - RB1_RW = 0 for exactly 1 cycle on a write, 1 on a read.
  - With no accepted command: RB1_RW = 1, and RB1_A and RB1_D hold their previous values.
- Read return: the owner tag is pipelined with the command. RB1_Q is captured into the owner's rdata, with rvalid pulsed, 1 cycle after RB1_A is driven.
  - Reads still in flight complete even if the grant has moved on.
- Non-owner rvalid never pulses. A cmd_valid while gnt is low produces no bank activity.
- Reset (at any time, including mid-burst): outputs go immediately to these values:
  - RB1_RW = 1, RB1_A = 0, RB1_D = 0
  - gnt = 0, rvalid = 0, rdata = 0
  - Internal state: FSM = IDLE, pointer = 1, in-flight reads discarded.

## Timing
- req high in IDLE at cycle t: gnt high at t+1.
- Command accepted at cycle n:
  - RB1_A/RW/D valid in cycle n+1.
  - rvalid/rdata in cycle n+2 (read latency 2).
- Sustained throughput: 1 command per cycle.
- A write at cycle n followed by a read of the same address at n+1 returns the new data.
- Handover: owner drops req at cycle t, TURN is at t+1, the other master's gnt is at t+2.

## Configuration
- RB1_ARB_BURST_LIMIT_EN defined:
  - In GN, on the edge that accepts the MAX_BURST-th command while the other req is high, go to TURN regardless of own req.
  - The preempted master sees gnt low, must hold its req, and is re-granted after the other master's burst.
  - With the other req low, the counter saturates and no preemption occurs.
- Undefined: no counter logic, and a grant lasts until the owner drops req. MAX_BURST is unused.

## Test plan
- Single master read: bank[5] = 0xA5. m0_req at cycle 0, gnt at 1, read addr 5 at 1 -> RB1_A = 5 in cycle 2; m0_rvalid = 1 with m0_rdata = 0xA5 in cycle 3; m1_rvalid stays 0.
- Tie and fairness: both reqs rise together after reset -> m0 granted. m0 drops req -> one TURN cycle -> m1 granted. Second simultaneous tie from IDLE -> m0 wins (m1 served last).
- Write-then-read: m1 writes 0x3C to addr 17 -> RB1_RW = 0 for exactly 1 cycle with RB1_A = 17, RB1_D = 0x3C. m1 reads 17 the next cycle -> m1_rdata = 0x3C.
- Ignored command: m1_cmd_valid pulsed while m0 holds grant -> no RB1_RW = 0 pulse, RB1_A unchanged from m0 traffic.
- Burst limit (macro on): m0 streams 20 reads with m1_req high -> exactly 18 accepted, TURN, m1 granted. Macro off: all 20 accepted before handover.
- Reset mid-burst: rst during G1 with a read in flight -> no rvalid; all outputs at reset values. After release, a tie goes to m0.
